// File: rtl/instr_encoder_loader.sv
// Assembles RV32I instruction words from class + field inputs and writes them
// sequentially into instruction memory, with immediate range checks and a fill pointer.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            kind,
  input  logic [2:0]            func3,
  input  logic                  alt,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    wr_en_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [31:0]             wr_data_r;
  logic [ADDR_WIDTH:0]     count_r;
  logic                    full_r;
  logic                    err_r;

  logic [31:0]             enc_data_s;
  logic                    enc_reject_s;
  logic [ADDR_WIDTH:0]     count_next_s;

  // True when bits [31:lsb] of v are all equal, i.e. v fits a signed field whose sign bit is lsb.
  function automatic logic sign_ok(input logic [31:0] v, input int lsb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << lsb;
    return ((v & mask) == mask) || ((v & mask) == 32'd0);
  endfunction

  // Field assembly and range check for the presented instruction class
  always_comb begin
    enc_data_s   = 32'd0;
    enc_reject_s = 1'b0;
    case (kind)
      3'd0: enc_data_s = {1'b0, alt, 5'b00000, rs2, rs1, func3, rd, OP_R};
      3'd1: begin
        enc_data_s   = {imm[11:0], rs1, func3, rd, OP_I};
        enc_reject_s = ~sign_ok(imm, 11);
      end
      3'd2: begin
        enc_data_s   = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_S};
        enc_reject_s = ~sign_ok(imm, 11);
      end
      3'd3: begin
        enc_data_s   = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_B};
        // Only BEQ/BNE/BLT/BGE exist in the controller's branch mapping
        enc_reject_s = imm[0] | ~sign_ok(imm, 12) | func3[2];
      end
      3'd4: begin
        enc_data_s   = {imm[31:12], rd, OP_U};
        enc_reject_s = |imm[11:0];
      end
      3'd5: begin
        enc_data_s   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
        enc_reject_s = imm[0] | ~sign_ok(imm, 20);
      end
      3'd6: begin
        enc_data_s   = {imm[11:0], rs1, 3'b010, rd, OP_LW};
        enc_reject_s = ~sign_ok(imm, 11);
      end
      3'd7: begin
        enc_data_s   = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        enc_reject_s = ~sign_ok(imm, 11);
      end
      default: begin
        enc_data_s   = 32'd0;
        enc_reject_s = 1'b1;
      end
    endcase
  end

  // Saturating fill-pointer increment
  always_comb begin
    if (count_r == DEPTH_C) begin
      count_next_s = count_r;
    end else begin
      count_next_s = count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  // Load FSM with registered write port, fill pointer and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_data_r <= 32'd0;
      count_r   <= {(ADDR_WIDTH+1){1'b0}};
      full_r    <= 1'b0;
      err_r     <= 1'b0;
    end else if (clear) begin
      state_r   <= IDLE;
      wr_en_r   <= 1'b0;
      count_r   <= {(ADDR_WIDTH+1){1'b0}};
      full_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wr_en_r <= 1'b0;
          if (in_valid) begin
            if (enc_reject_s) begin
              err_r <= 1'b1;
            end else begin
              wr_data_r <= enc_data_s;
              wr_addr_r <= count_r[ADDR_WIDTH-1:0];
              wr_en_r   <= 1'b1;
              state_r   <= WRITE;
            end
          end
        end
        WRITE: begin
          wr_en_r <= 1'b0;
          count_r <= count_next_s;
          if (count_next_s == DEPTH_C) begin
            full_r  <= 1'b1;
            state_r <= FULL;
          end else begin
            state_r <= IDLE;
          end
        end
        FULL: begin
          wr_en_r <= 1'b0;
          full_r  <= 1'b1;
        end
        default: begin
          wr_en_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // rst/clear gate the strobe immediately so an in-flight write is dropped in that cycle
  assign in_ready = (state_r == IDLE) & ~clear & ~rst;
  assign wr_en    = wr_en_r & ~clear & ~rst;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign count    = count_r;
  assign full     = full_r;
  assign err      = err_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed, table-driven bench for instr_encoder_loader: a default-depth instance
// for encoding/reject/throughput checks and a 4-word instance for the full condition.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, clear, valid_a, valid_b;
  logic [2:0]  kind, func3;
  logic        alt;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        ready_a, wr_en_a, full_a, err_a;
  logic [7:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [8:0]  count_a;

  logic        ready_b, wr_en_b, full_b, err_b;
  logic [1:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [2:0]  count_b;

  always #5 clk = ~clk;

  instr_encoder_loader dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(valid_a), .in_ready(ready_a),
    .kind(kind), .func3(func3), .alt(alt), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .count(count_a),
    .full(full_a), .err(err_a)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(valid_b), .in_ready(ready_b),
    .kind(kind), .func3(func3), .alt(alt), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .count(count_b),
    .full(full_b), .err(err_b)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        rej;
  } vec_t;

  vec_t vt[14];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    kind = v.kind; func3 = v.f3; alt = v.alt;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  task automatic addi(input logic [4:0] d, input logic [31:0] val);
    kind = 3'd1; func3 = 3'd0; alt = 1'b0; rd = d; rs1 = 5'd0; rs2 = 5'd0; imm = val;
  endtask

  initial begin
    int   cnt;
    logic errm;
    logic exp_en;
    vec_t v;

    rst = 1'b1; clear = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    kind = 3'd0; func3 = 3'd0; alt = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;

    // Encoding vectors: kind, func3, alt, rd, rs1, rs2, imm, expected word, reject
    vt[0]  = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0020_81B3, 1'b0};
    vt[1]  = '{3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h4020_81B3, 1'b0};
    vt[2]  = '{3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0};
    vt[3]  = '{3'd6, 3'd7, 1'b0, 5'd6, 5'd2, 5'd0, 32'h0000_0008, 32'h0081_2303, 1'b0};
    vt[4]  = '{3'd2, 3'd0, 1'b0, 5'd0, 5'd2, 5'd7, 32'h0000_000C, 32'h0071_2623, 1'b0};
    vt[5]  = '{3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
    vt[6]  = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0};
    vt[7]  = '{3'd4, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5237, 1'b0};
    vt[8]  = '{3'd7, 3'd3, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_00E7, 1'b0};
    vt[9]  = '{3'd1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'h0000_0800, 32'h0000_0000, 1'b1};
    vt[10] = '{3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_0003, 32'h0000_0000, 1'b1};
    vt[11] = '{3'd4, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0000, 1'b1};
    vt[12] = '{3'd3, 3'd4, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0000_0000, 1'b1};
    vt[13] = '{3'd1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'h0000_0005, 32'h0050_8093, 1'b0};

    // Reset state
    tick();
    chk("ready_during_rst", 32'(ready_a), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en_a), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr_a), 32'd0);
    chk("rst_wr_data", wr_data_a, 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);

    // Table: encodings and rejects
    cnt = 0;
    errm = 1'b0;
    for (int i = 0; i < 14; i++) begin
      v = vt[i];
      apply(v);
      valid_a = 1'b1;
      #1;
      chk($sformatf("ready_v%0d", i), 32'(ready_a), 32'd1);
      tick();
      valid_a = 1'b0;
      if (!v.rej) begin
        chk($sformatf("wr_en_v%0d", i), 32'(wr_en_a), 32'd1);
        chk($sformatf("wr_addr_v%0d", i), 32'(wr_addr_a), 32'(cnt));
        chk($sformatf("wr_data_v%0d", i), wr_data_a, v.exp);
        tick();
        cnt++;
        chk($sformatf("wr_en_off_v%0d", i), 32'(wr_en_a), 32'd0);
        chk($sformatf("hold_v%0d", i), wr_data_a, v.exp);
      end else begin
        errm = 1'b1;
        chk($sformatf("no_write_v%0d", i), 32'(wr_en_a), 32'd0);
      end
      chk($sformatf("count_v%0d", i), 32'(count_a), 32'(cnt));
      chk($sformatf("err_v%0d", i), 32'(err_a), 32'(errm));
    end

    // Continuous in_valid: one accept every other cycle
    addi(5'd2, 32'd1);
    valid_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_en = (k % 2 == 0);
      chk($sformatf("stream_en%0d", k), 32'(wr_en_a), 32'(exp_en));
      if (exp_en) begin
        chk($sformatf("stream_addr%0d", k), 32'(wr_addr_a), 32'(cnt));
        chk($sformatf("stream_data%0d", k), wr_data_a, 32'h0010_0113);
      end else begin
        cnt++;
        chk($sformatf("stream_count%0d", k), 32'(count_a), 32'(cnt));
      end
    end
    valid_a = 1'b0;

    // clear together with in_valid in IDLE: not accepted
    clear = 1'b1;
    valid_a = 1'b1;
    #1;
    chk("clear_ready", 32'(ready_a), 32'd0);
    tick();
    clear = 1'b0;
    valid_a = 1'b0;
    #1;
    chk("clear_no_wr", 32'(wr_en_a), 32'd0);
    chk("clear_count", 32'(count_a), 32'd0);
    chk("clear_err", 32'(err_a), 32'd0);

    // rst asserted during a WRITE cycle
    addi(5'd9, 32'd7);
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    chk("pre_rst_wr_en", 32'(wr_en_a), 32'd1);
    chk("pre_rst_addr", 32'(wr_addr_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_write_wr_en", 32'(wr_en_a), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_wr_en", 32'(wr_en_a), 32'd0);
    chk("post_rst_addr", 32'(wr_addr_a), 32'd0);
    chk("post_rst_data", wr_data_a, 32'd0);
    chk("post_rst_count", 32'(count_a), 32'd0);
    chk("post_rst_full", 32'(full_a), 32'd0);

    // Small instance: reject, then fill all 4 words
    addi(5'd1, 32'h0000_0800);
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    chk("b_rej_wr_en", 32'(wr_en_b), 32'd0);
    chk("b_rej_err", 32'(err_b), 32'd1);
    for (int i = 0; i < 4; i++) begin
      addi(5'(i), 32'(i));
      valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      chk($sformatf("b_wr_en%0d", i), 32'(wr_en_b), 32'd1);
      chk($sformatf("b_addr%0d", i), 32'(wr_addr_b), 32'(i));
      chk($sformatf("b_data%0d", i), wr_data_b, {12'(i), 5'd0, 3'd0, 5'(i), 7'b0010011});
      tick();
      chk($sformatf("b_count%0d", i), 32'(count_b), 32'(i + 1));
    end
    chk("b_full", 32'(full_b), 32'd1);
    chk("b_ready_full", 32'(ready_b), 32'd0);

    // 5th request while full is ignored
    addi(5'd5, 32'd5);
    valid_b = 1'b1;
    tick();
    chk("b_full_no_wr0", 32'(wr_en_b), 32'd0);
    tick();
    chk("b_full_no_wr1", 32'(wr_en_b), 32'd0);
    chk("b_full_count", 32'(count_b), 32'd4);
    chk("b_full_addr_hold", 32'(wr_addr_b), 32'd3);
    valid_b = 1'b0;

    // clear restarts the small instance at address 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("b_clr_count", 32'(count_b), 32'd0);
    chk("b_clr_full", 32'(full_b), 32'd0);
    chk("b_clr_err", 32'(err_b), 32'd0);
    chk("b_clr_ready", 32'(ready_b), 32'd1);
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    chk("b_after_clr_wr_en", 32'(wr_en_b), 32'd1);
    chk("b_after_clr_addr", 32'(wr_addr_b), 32'd0);
    chk("b_after_clr_data", wr_data_b, 32'h0050_0293);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the pipeline's main controller. The controller decodes opcode/func3 into control signals; this block does the reverse.
- It takes an instruction class plus register/immediate fields, assembles the 32-bit RV32I word and writes it sequentially into instruction memory through a write port.
- Used by testbenches and the boot loader to program the core.
- Range-checks immediates, keeps a sticky error flag and tracks a fill pointer up to a full condition.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction-memory write port. DEPTH = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous restart: pointer to 0, error cleared
- in_valid  input  1  instruction fields valid
- in_ready  output  1  block can accept fields
- kind  input  3  class: 0 R, 1 I, 2 S, 3 B, 4 U(LUI), 5 J(JAL), 6 LW, 7 JALR
- func3  input  3  funct3 field
- alt  input  1  funct7[5] for R class (SUB)
- rd  input  5  destination register
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- imm  input  32  signed byte immediate (U: full upper value)
- wr_en  output  1  memory write strobe
- wr_addr  output  ADDR_WIDTH  word address
- wr_data  output  32  encoded instruction
- count  output  ADDR_WIDTH+1  words written since reset/clear
- full  output  1  DEPTH words written
- err  output  1  sticky: a rejected instruction was seen

Behaviour:
- Reset and outputs
  - Reset: state IDLE; wr_en, wr_addr, wr_data, count, full and err are all 0.
  - in_ready = (state==IDLE) && !clear && !rst, so it is 0 while rst is high.
- Opcodes used: R 0110011, I 0010011, S 0100011, B 1100011, U 0110111, J 1101111, LW 0000011, JALR 1100111.
- Encoding by class
  - R: {0,alt,00000, rs2, rs1, func3, rd, op}.
  - I: {imm[11:0], rs1, func3, rd, op}.
  - LW: as I with funct3 forced to 010.
  - JALR: as I with funct3 forced to 000.
  - S: {imm[11:5], rs2, rs1, 010, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Reject conditions (no write, err set to 1)
  - I/S/LW/JALR: imm[31:11] not all equal.
  - B: imm[0]≠0 or imm[31:12] not all equal.
  - B: func3 outside {000 BEQ, 001 BNE, 010 BLT, 011 BGE}; this is the controller's mapping.
  - J: imm[0]≠0 or imm[31:20] not all equal.
  - U: imm[11:0]≠0.
- FSM
  - IDLE: on in_valid && in_ready:
    - If rejected: set err, stay IDLE.
    - Otherwise: register wr_data and set wr_addr = count[ADDR_WIDTH-1:0]; go to WRITE.
  - WRITE: wr_en=1 for exactly this cycle; count increments at the clock edge that ends it.
    - If count+1 == DEPTH: go to FULL.
    - Otherwise: go to IDLE.
  - FULL: full=1, in_ready=0; stays until clear or rst.
- Latency and throughput
  - Accept at cycle T gives wr_en at T+1.
  - Maximum throughput is one instruction per 2 cycles.
  - wr_data and wr_addr hold their last values when wr_en=0.
- clear
  - Highest priority after rst, in any state.
  - Sets count=0, full=0, err=0 and state IDLE.
  - wr_en is 0 in the clear cycle, so a pending WRITE is aborted.
  - Input is not accepted in the clear cycle.
- rst asserted mid-WRITE: no wr_en in that cycle; everything returns to reset values.
- count saturates at DEPTH and never wraps; wr_addr never wraps past DEPTH-1.

Test Plan:
- Reset, then encode in sequence:
  - R ADD x3,x1,x2 -> 0x002081B3
  - R alt=1 -> 0x402081B3
  - I ADDI x5,x0,-1 -> 0xFFF00293
  - LW x6,8(x2) -> 0x00812303
  - Expect wr_addr 0..3, wr_en one cycle after each accept, count=4.
- S SW x7,12(x2) -> 0x00712623.
- B BEQ x1,x2,imm=0xFFFFFFFC -> 0xFE208EE3.
- J JAL x1,8 -> 0x008000EF.
- U LUI x4,0x12345000 -> 0x12345237.
- Rejects: ADDI imm=2048, BEQ imm=3, LUI imm=0x12345001, B func3=100.
  - Each gives err=1, no wr_en, count unchanged.
  - A following valid ADDI still writes.
- ADDR_WIDTH=2: write 4 valid instructions.
  - Expect full=1, count=4, in_ready=0; a 5th in_valid is ignored.
  - clear -> count=0, full=0, err=0; the next write goes to wr_addr=0.
- Edge cases:
  - Assert clear together with in_valid in IDLE -> not accepted.
  - Assert rst in a WRITE cycle -> wr_en=0, all outputs 0.
  - Hold in_valid continuously -> accepts every other cycle.
